// File: rtl/alloc_ctrl.sv
// Dispatch-side controller for one allocator instance: capacity gating, grant
// encoding, shadow busy/free tracking and flush recovery via bulk clear.
module alloc_ctrl #(
  parameter int unsigned NUM_RESOURCES = 64,
  parameter int unsigned NUM_REQUESTS  = 3,
  parameter int unsigned IDX_W         = $clog2(NUM_RESOURCES),
  parameter int unsigned CNT_W         = $clog2(NUM_RESOURCES + 1),
  localparam int unsigned DC_W         = $clog2(NUM_REQUESTS + 1)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        disp_valid,
  input  logic [DC_W-1:0]                             disp_count,
  output logic                                        disp_ready,
  output logic [NUM_REQUESTS-1:0][IDX_W-1:0]          disp_idx,
  input  logic [NUM_RESOURCES-1:0]                    release_mask,
  input  logic                                        flush,
  input  logic [NUM_RESOURCES-1:0]                    flush_mask,
  output logic [NUM_REQUESTS-1:0]                     alloc_req,
  output logic [NUM_RESOURCES-1:0]                    alloc_clear,
  input  logic [NUM_REQUESTS-1:0][NUM_RESOURCES-1:0]  alloc_grant,
  output logic [CNT_W-1:0]                            free_count,
  output logic [NUM_RESOURCES-1:0]                    busy,
  output logic                                        recovering,
  output logic                                        alloc_err
);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t                   state, state_next;
  logic [NUM_RESOURCES-1:0] flush_mask_q, flush_mask_next;
  logic [NUM_RESOURCES-1:0] busy_next, grant_or;
  logic [CNT_W-1:0]         free_next, clear_pop, row_cnt;
  logic                     fire, err_hit;

  assign recovering = (state == RECOVER);

  always_comb begin
    disp_ready = (state == RUN) && !flush && (CNT_W'(disp_count) <= free_count);
    fire       = disp_valid && disp_ready;

    for (int unsigned k = 0; k < NUM_REQUESTS; k++) begin
      alloc_req[k] = fire && (DC_W'(k) < disp_count);
    end

    // OR-encoding yields the index for a one-hot row and 0 for an empty row
    for (int unsigned k = 0; k < NUM_REQUESTS; k++) begin
      disp_idx[k] = '0;
      for (int unsigned j = 0; j < NUM_RESOURCES; j++) begin
        if (alloc_grant[k][j]) disp_idx[k] = disp_idx[k] | IDX_W'(j);
      end
    end

    alloc_clear = (release_mask | (recovering ? flush_mask_q : '0)) & busy;

    clear_pop = '0;
    for (int unsigned j = 0; j < NUM_RESOURCES; j++) begin
      clear_pop = clear_pop + CNT_W'(alloc_clear[j]);
    end

    grant_or = '0;
    err_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQUESTS; k++) begin
      row_cnt = '0;
      for (int unsigned j = 0; j < NUM_RESOURCES; j++) begin
        row_cnt = row_cnt + CNT_W'(alloc_grant[k][j]);
      end
      if (alloc_req[k]) begin
        grant_or = grant_or | alloc_grant[k];
        if (row_cnt != CNT_W'(1) || (alloc_grant[k] & busy) != '0) err_hit = 1'b1;
      end
    end

    busy_next = (busy & ~alloc_clear) | grant_or;
    free_next = free_count + clear_pop - (fire ? CNT_W'(disp_count) : '0);

    state_next      = state;
    flush_mask_next = flush_mask_q;
    case (state)
      RUN: begin
        if (flush) begin
          state_next      = RECOVER;
          flush_mask_next = flush_mask;
        end
      end
      RECOVER: begin
        if (flush) flush_mask_next = flush_mask;
        else       state_next      = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      busy         <= '0;
      free_count   <= CNT_W'(NUM_RESOURCES);
      flush_mask_q <= '0;
      alloc_err    <= 1'b0;
    end else begin
      state        <= state_next;
      busy         <= busy_next;
      free_count   <= free_next;
      flush_mask_q <= flush_mask_next;
      if (err_hit) alloc_err <= 1'b1;
    end
  end

endmodule

// File: doc/alloc_ctrl.md
# alloc_ctrl

Dispatch-side controller for the generic resource allocator: gates dispatch on available capacity, drives the allocator's `req`/`clear`, encodes one-hot grants into indices, and keeps a shadow busy vector and free count. It sits between the decode/dispatch stage and one allocator instance (phys-reg free list, RS, ROB or LSQ). It sequences flush recovery by bulk-freeing squashed resources through the allocator's `clear` port.

## Interface
- `NUM_RESOURCES`, default 64: pool size; must match the allocator instance.
- `NUM_REQUESTS`, default 3: dispatch width; must match the allocator instance.
- `IDX_W`, default `$clog2(NUM_RESOURCES)`: derived; index width.
- `CNT_W`, default `$clog2(NUM_RESOURCES+1)`: derived; free-count width.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `disp_valid`  in  1  dispatch group wants resources.
- `disp_count`  in  `$clog2(NUM_REQUESTS+1)`  resources needed, 0..NUM_REQUESTS.
- `disp_ready`  out  1  group accepted this cycle (all-or-nothing).
- `disp_idx`  out  [NUM_REQUESTS][IDX_W]  granted index per slot k; valid for k<disp_count on fire.
- `release_mask`  in  NUM_RESOURCES  resources freed at retire.
- `flush`  in  1  squash request.
- `flush_mask`  in  NUM_RESOURCES  resources to free on squash.
- `alloc_req`  out  NUM_REQUESTS  to allocator `req`.
- `alloc_clear`  out  NUM_RESOURCES  to allocator `clear`.
- `alloc_grant`  in  [NUM_REQUESTS][NUM_RESOURCES]  from allocator `grant`.
- `free_count`  out  CNT_W  registered count of free resources.
- `busy`  out  NUM_RESOURCES  registered shadow allocation vector.
- `recovering`  out  1  high in RECOVER state.
- `alloc_err`  out  1  sticky consistency error.

## Operation
- States: RUN, RECOVER. Reset enters RUN.
- `disp_ready` = RUN & !flush & (disp_count <= free_count).
- fire = disp_valid & disp_ready.
- On fire, `alloc_req` = thermometer of disp_count, i.e. bits [disp_count-1:0]. Otherwise `alloc_req` = 0. A fire with disp_count = 0 is legal and allocates nothing.
- `disp_idx[k]` = binary encode of `alloc_grant[k]`; 0 when the row is zero.
- `alloc_clear` = (release_mask | (RECOVER ? flush_mask_q : 0)) & busy. Clear bits for resources that are not busy are dropped.
- Next-state update:
  - busy_next = (busy & ~alloc_clear) | OR of granted rows k<disp_count.
  - free_count_next = free_count + popcount(alloc_clear) − (fire ? disp_count : 0).
  - Grants and clears are disjoint by construction.
- Invariant: free_count == NUM_RESOURCES − popcount(busy).
- Flush seen in RUN: no fire that cycle; flush_mask_q <= flush_mask; next state RECOVER.
- In RECOVER: flush_mask_q is applied via `alloc_clear`; disp_ready = 0.
  - If flush is low, next state is RUN.
  - If flush is high, flush_mask_q <= flush_mask and the block stays in RECOVER one more cycle.
- Releases are honoured in both states.
- alloc_err sets and holds until reset when, on fire, any slot k<disp_count has a grant row that is not one-hot or that hits a busy bit.

## Timing
- `disp_ready`, `alloc_req`, `disp_idx`, `alloc_clear`: combinational, same cycle.
- `busy`, `free_count`, state: update at the next rising edge.
- A released resource counts in free_count and is grantable from the cycle after the release.
- Flush bubble: dispatch is blocked in the flush cycle and the RECOVER cycle, and resumes in the cycle after RECOVER (2-cycle minimum).
- Reset values, applied asynchronously with no clock edge needed:
  - state RUN, busy 0, free_count NUM_RESOURCES, flush_mask_q 0.
  - recovering 0, alloc_err 0.
- Reset must be held across at least one rising edge so the synchronously-reset allocator also clears.
- A reset asserted during RECOVER abandons the pending flush.

## Test plan
Parameters for all scenarios: NUM_RESOURCES=8, NUM_REQUESTS=3.
- Reset, then dispatch count 3 -> ready=1, alloc_req=3'b111, three distinct disp_idx; next cycle free_count=5, popcount(busy)=3, alloc_err=0.
- Dispatch 3, 3 -> free_count=2. Request 3 -> ready=0, alloc_req=0. Request 2 -> fires; free_count=0. Request 0 -> fires with alloc_req=0.
- Dispatch 1 while release_mask holds one busy bit and one non-busy bit -> alloc_clear has only the busy bit; free_count unchanged (+1−1).
- Busy=8'hFF; flush with mask 8'h0F -> ready=0 that cycle; next cycle recovering=1, alloc_clear=8'h0F, ready=0; following cycle RUN, free_count=4, busy=8'hF0.
- Flush again during RECOVER with mask 8'h30 -> recovering stays high one more cycle with alloc_clear=8'h30; final free_count=6.
- Assert reset mid-dispatch without a clock edge -> free_count=8, busy=0, recovering=0 immediately; after the release edge, a count-3 dispatch succeeds.
